mac_memory_loader: RTL and testbench

MAC_MEMORY_LOADER -- requirements
Module: mac_memory_loader

---
 rtl/mac_memory_loader.sv | 185 ++++++++++++++++++
 tb/tb_mac_memory_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_memory_loader.sv
// mac_memory_loader: parses a framed host byte stream (sync, bank, base
// address, word count, 16-bit words, XOR checksum) and issues one-cycle
// write strobes into the weights or activations memory of the MAC array.
module mac_memory_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MEM_DEPTH = 256,
    localparam int        AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          load_done,
    output logic          load_error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BANK  = 3'd1;
    localparam logic [2:0] S_BASE  = 3'd2;
    localparam logic [2:0] S_COUNT = 3'd3;
    localparam logic [2:0] S_LO    = 3'd4;
    localparam logic [2:0] S_HI    = 3'd5;
    localparam logic [2:0] S_WRITE = 3'd6;
    localparam logic [2:0] S_CSUM  = 3'd7;

    logic [2:0]    state_q, state_d;
    logic          readyEn_q;
    logic          bank_q, bank_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    csum_q, csum_d;
    logic          wrEn_q, wrEn_d;
    logic          wrBank_q, wrBank_d;
    logic [AW-1:0] wrAddr_q, wrAddr_d;
    logic [15:0]   wrData_q, wrData_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          accept;

    // The ready enable is a register so in_ready stays low through reset and
    // only comes up on the first clock edge after release; the WRITE cycle
    // is the single cycle in which no byte is taken.
    assign in_ready   = readyEn_q && (state_q != S_WRITE);
    assign accept     = in_valid && in_ready;
    assign wr_en      = wrEn_q;
    assign wr_bank    = wrBank_q;
    assign wr_addr    = wrAddr_q;
    assign wr_data    = wrData_q;
    assign busy       = (state_q != S_IDLE);
    assign load_done  = done_q;
    assign load_error = error_q;

    // Frame parser: every accepting state consumes one byte and folds it into
    // the running checksum; the write port registers are only loaded on the
    // HI byte so they hold the last written word between strobes.
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        addr_d   = addr_q;
        count_d  = count_q;
        lo_d     = lo_q;
        csum_d   = csum_q;
        wrEn_d   = 1'b0;
        wrBank_d = wrBank_q;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        done_d   = 1'b0;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = S_BANK;
                    error_d = 1'b0;
                    csum_d  = 8'h00;
                end
            end
            S_BANK: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (in_data[7:1] == 7'd0) begin
                        bank_d  = in_data[0];
                        state_d = S_BASE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_BASE: begin
                if (accept) begin
                    csum_d  = csum_q ^ in_data;
                    addr_d  = in_data[AW-1:0];
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    csum_d  = csum_q ^ in_data;
                    count_d = in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    csum_d  = csum_q ^ in_data;
                    lo_d    = in_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    csum_d   = csum_q ^ in_data;
                    wrEn_d   = 1'b1;
                    wrBank_d = bank_q;
                    wrAddr_d = addr_q;
                    wrData_d = {in_data, lo_q};
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 1'b1;
                if (count_q == 8'd0) begin
                    state_d = S_CSUM;
                end else begin
                    count_d = count_q - 8'd1;
                    state_d = S_LO;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; an asserted reset aborts any frame at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            readyEn_q <= 1'b0;
            bank_q    <= 1'b0;
            addr_q    <= '0;
            count_q   <= 8'h00;
            lo_q      <= 8'h00;
            csum_q    <= 8'h00;
            wrEn_q    <= 1'b0;
            wrBank_q  <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= 16'h0000;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            readyEn_q <= 1'b1;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            lo_q      <= lo_d;
            csum_q    <= csum_d;
            wrEn_q    <= wrEn_d;
            wrBank_q  <= wrBank_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_mac_memory_loader.sv
// tb_mac_memory_loader: directed frames with hand-computed checksums and
// expected memory writes for mac_memory_loader.
module tb_mac_memory_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic        wr_bank;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int assertCount = 0;
    int failCount   = 0;

    logic [24:0] wlog[$];
    logic [7:0]  frameBytes[$];
    int          doneCount      = 0;
    int          notReadyCycles = 0;
    logic        overlapSeen    = 1'b0;

    mac_memory_loader #(.SYNC_BYTE(8'hA5), .MEM_DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe outputs on the falling edge: log write strobes, count done
    // pulses and stalled cycles, and flag any write/done overlap.
    always @(negedge clk) begin
        if (reset && wr_en) wlog.push_back({wr_bank, wr_addr, wr_data});
        if (load_done) doneCount++;
        if (wr_en && load_done) overlapSeen = 1'b1;
        if (reset && !in_ready) notReadyCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one byte from the falling edge and hold it until it is taken.
    task automatic applyStimulus(input logic [7:0] b);
        int waitCycles;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
        else @(posedge clk);
    endtask

    task automatic idleInput();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sendFrame();
        foreach (frameBytes[i]) applyStimulus(frameBytes[i]);
        idleInput();
        repeat (3) @(negedge clk);
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic bank,
                              input logic [7:0] addr, input logic [15:0] data);
        checkOutput(tag, (idx < wlog.size()) ? {7'd0, wlog[idx]} : 32'hFFFF_FFFF,
                    {7'd0, bank, addr, data});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        checkOutput({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
        checkOutput({tag, "_wr_bank"},    {31'd0, wr_bank},    32'd0);
        checkOutput({tag, "_wr_addr"},    {24'd0, wr_addr},    32'd0);
        checkOutput({tag, "_wr_data"},    {16'd0, wr_data},    32'd0);
        checkOutput({tag, "_busy"},       {31'd0, busy},       32'd0);
        checkOutput({tag, "_load_done"},  {31'd0, load_done},  32'd0);
        checkOutput({tag, "_load_error"}, {31'd0, load_error}, 32'd0);
    endtask

    initial begin
        in_data  = 8'h00;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1 reset = 1'b0;
        #2;
        $display("[TB] reset state");
        checkResetValues("reset");
        @(negedge clk);
        reset = 1'b1;
        #2 checkOutput("ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 checkOutput("ready_after_edge", {31'd0, in_ready}, 32'd1);

        // Two words into bank 0 at 0x10; checksum 00^10^01^34^12^CD^AB = 51.
        $display("[TB] frame bank0 base 10");
        wlog.delete(); doneCount = 0;
        frameBytes = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h51};
        sendFrame();
        checkOutput("a_nwrites", wlog.size(), 32'd2);
        checkWrite("a_write0", 0, 1'b0, 8'h10, 16'h1234);
        checkWrite("a_write1", 1, 1'b0, 8'h11, 16'hABCD);
        checkOutput("a_done", doneCount, 32'd1);
        checkOutput("a_error", {31'd0, load_error}, 32'd0);
        checkOutput("a_busy", {31'd0, busy}, 32'd0);
        checkOutput("a_hold_addr", {24'd0, wr_addr}, 32'h11);
        checkOutput("a_hold_data", {16'd0, wr_data}, 32'hABCD);

        // Bank 1 wrapping from 0xFF to 0x00; checksum 01^FF^01^01^00^02^00 = FC.
        $display("[TB] frame bank1 wrap");
        wlog.delete(); doneCount = 0;
        frameBytes = '{8'hA5, 8'h01, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 8'hFC};
        sendFrame();
        checkOutput("b_nwrites", wlog.size(), 32'd2);
        checkWrite("b_write0", 0, 1'b1, 8'hFF, 16'h0001);
        checkWrite("b_write1", 1, 1'b1, 8'h00, 16'h0002);
        checkOutput("b_done", doneCount, 32'd1);
        checkOutput("b_hold_bank", {31'd0, wr_bank}, 32'd1);

        // Illegal bank byte, then recovery on the next frame.
        $display("[TB] bad bank");
        wlog.delete(); doneCount = 0;
        frameBytes = '{8'hA5, 8'h02};
        sendFrame();
        checkOutput("badbank_error", {31'd0, load_error}, 32'd1);
        checkOutput("badbank_nwrites", wlog.size(), 32'd0);
        checkOutput("badbank_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'hA5);
        #1;
        checkOutput("resync_error_clear", {31'd0, load_error}, 32'd0);
        checkOutput("resync_busy", {31'd0, busy}, 32'd1);
        frameBytes = '{8'h00, 8'h10, 8'h01, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h51};
        sendFrame();
        checkOutput("resync_done", doneCount, 32'd1);
        checkOutput("resync_nwrites", wlog.size(), 32'd2);

        // Corrupted checksum: writes remain, error set, no done.
        $display("[TB] bad checksum");
        wlog.delete(); doneCount = 0;
        frameBytes = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h50};
        sendFrame();
        checkOutput("badcsum_nwrites", wlog.size(), 32'd2);
        checkWrite("badcsum_write1", 1, 1'b0, 8'h11, 16'hABCD);
        checkOutput("badcsum_error", {31'd0, load_error}, 32'd1);
        checkOutput("badcsum_done", doneCount, 32'd0);

        // 256 words from base 0x80, lo = i, hi = i^5A; each word pair XORs to
        // 5A an even number of times, so checksum = 00^80^FF = 7F.
        $display("[TB] 256-word frame");
        wlog.delete(); doneCount = 0; notReadyCycles = 0;
        frameBytes = '{8'hA5, 8'h00, 8'h80, 8'hFF};
        for (int i = 0; i < 256; i++) begin
            frameBytes.push_back(8'(i));
            frameBytes.push_back(8'(i) ^ 8'h5A);
        end
        frameBytes.push_back(8'h7F);
        sendFrame();
        checkOutput("full_nwrites", wlog.size(), 32'd256);
        checkOutput("full_stall_cycles", notReadyCycles, 32'd256);
        checkOutput("full_done", doneCount, 32'd1);
        checkOutput("full_error", {31'd0, load_error}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            checkWrite("full_write", i, 1'b0, 8'(8'h80 + i), {8'(i) ^ 8'h5A, 8'(i)});
        end
        checkOutput("no_wr_done_overlap", {31'd0, overlapSeen}, 32'd0);

        // Reset right after the second write of a 4-word frame.
        $display("[TB] reset mid-frame");
        wlog.delete(); doneCount = 0;
        frameBytes = '{8'hA5, 8'h00, 8'h20, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22};
        foreach (frameBytes[i]) applyStimulus(frameBytes[i]);
        @(negedge clk);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkResetValues("midreset");
        checkOutput("midreset_nwrites", wlog.size(), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(8'h33);
        applyStimulus(8'h33);
        idleInput();
        repeat (3) @(negedge clk);
        checkOutput("postreset_nowrite", wlog.size(), 32'd2);
        checkOutput("postreset_busy", {31'd0, busy}, 32'd0);
        wlog.delete();
        // checksum 01^20^00^EF^BE = 70
        frameBytes = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'hEF, 8'hBE, 8'h70};
        sendFrame();
        checkOutput("postreset_nwrites", wlog.size(), 32'd1);
        checkWrite("postreset_write0", 0, 1'b1, 8'h20, 16'hBEEF);
        checkOutput("postreset_done", doneCount, 32'd1);
        checkOutput("postreset_error", {31'd0, load_error}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
